pause_arbiter: RTL and testbench

//  Arbitrates pause of the game core between user toggle, OSD-open and hiscore RAM requests.

---
 rtl/pause_arbiter.sv | 169 ++++++++++++++++
 tb/tb_pause_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pause_arbiter.sv
// Pause arbiter: merges user/OSD/hiscore pause requests, freezes the core on a vblank
// boundary, then grants hiscore RAM after a settle window. Optional dimming: PAUSE_ARB_DIM_EN.
module pause_arbiter #(
    parameter int SETTLE_CYCLES = 16,
    parameter int VBL_TIMEOUT   = 1_000_000,
    parameter int DIM_CYCLES    = 300_000_000,
    parameter int TW            = 32
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_pause,
    input  logic       i_osd_open,
    input  logic       i_osd_pause_en,
    input  logic       i_hs_req,
    input  logic       i_vblank,
    output logic       o_pause,
    output logic       o_hs_grant,
    output logic       o_user_paused,
    output logic       o_dim_video,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_VBL = 2'd1,
        ST_SETTLE   = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    localparam logic [TW-1:0] TMO_LAST = TW'(VBL_TIMEOUT - 1);
    localparam logic [TW-1:0] SET_LAST = TW'(SETTLE_CYCLES - 1);

    state_t        r_state;
    logic          r_btn_prev;
    logic          r_vbl_prev;
    logic          r_user_paused;
    logic          r_pause;
    logic          r_hs_grant;
    logic [TW-1:0] r_tmo_cnt;
    logic [TW-1:0] r_set_cnt;

    logic w_btn_rise;
    logic w_vbl_rise;
    logic w_want;

    assign w_btn_rise = i_btn_pause & ~r_btn_prev;
    assign w_vbl_rise = i_vblank & ~r_vbl_prev;
    assign w_want     = r_user_paused | (i_osd_open & i_osd_pause_en) | i_hs_req;

    // btn_prev resets high so a button held through reset is not seen as a press.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_btn_prev    <= 1'b1;
            r_vbl_prev    <= 1'b0;
            r_user_paused <= 1'b0;
        end else begin
            r_btn_prev <= i_btn_pause;
            r_vbl_prev <= i_vblank;
            if (w_btn_rise) begin
                r_user_paused <= ~r_user_paused;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_RUN;
            r_pause    <= 1'b0;
            r_hs_grant <= 1'b0;
            r_tmo_cnt  <= '0;
            r_set_cnt  <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_pause    <= 1'b0;
                    r_hs_grant <= 1'b0;
                    if (w_want) begin
                        r_state   <= ST_WAIT_VBL;
                        r_tmo_cnt <= '0;
                    end
                end
                ST_WAIT_VBL: begin
                    r_hs_grant <= 1'b0;
                    if (r_tmo_cnt != TMO_LAST) begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end
                    // A dropped request wins over a coincident vblank edge.
                    if (!w_want) begin
                        r_state <= ST_RUN;
                        r_pause <= 1'b0;
                    end else if (w_vbl_rise || (r_tmo_cnt == TMO_LAST)) begin
                        r_state   <= ST_SETTLE;
                        r_set_cnt <= '0;
                        r_pause   <= 1'b1;
                    end else begin
                        r_pause <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    r_hs_grant <= 1'b0;
                    if (r_set_cnt != SET_LAST) begin
                        r_set_cnt <= r_set_cnt + TW'(1);
                    end
                    if (!w_want) begin
                        r_state <= ST_RUN;
                        r_pause <= 1'b0;
                    end else begin
                        r_pause <= 1'b1;
                        // Grant is loaded on the way into HOLD so it lands with the state.
                        if (r_set_cnt == SET_LAST) begin
                            r_state    <= ST_HOLD;
                            r_hs_grant <= i_hs_req;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!w_want) begin
                        r_state    <= ST_RUN;
                        r_pause    <= 1'b0;
                        r_hs_grant <= 1'b0;
                    end else begin
                        r_pause    <= 1'b1;
                        r_hs_grant <= i_hs_req;
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_pause    <= 1'b0;
                    r_hs_grant <= 1'b0;
                end
            endcase
        end
    end

`ifdef PAUSE_ARB_DIM_EN
    localparam logic [TW-1:0] DIM_LAST = TW'(DIM_CYCLES);

    logic [TW-1:0] r_dim_cnt;
    logic [TW-1:0] w_dim_next;
    logic          r_dim_video;

    always_comb begin
        w_dim_next = '0;
        if ((r_state == ST_HOLD) && r_user_paused) begin
            w_dim_next = (r_dim_cnt == DIM_LAST) ? r_dim_cnt : r_dim_cnt + TW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dim_cnt   <= '0;
            r_dim_video <= 1'b0;
        end else begin
            r_dim_cnt   <= w_dim_next;
            r_dim_video <= (w_dim_next == DIM_LAST);
        end
    end

    assign o_dim_video = r_dim_video;
`else
    assign o_dim_video = 1'b0;
`endif

    assign o_pause       = r_pause;
    assign o_hs_grant    = r_hs_grant;
    assign o_user_paused = r_user_paused;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_pause_arbiter.sv
// Directed bench for pause_arbiter (SETTLE_CYCLES=4, VBL_TIMEOUT=100, DIM_CYCLES=10).
// Cycle c is the interval after the c-th clock edge following reset release.
module tb_pause_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_pause = 1'b0;
  logic       osd_open = 1'b0;
  logic       osd_pause_en = 1'b0;
  logic       hs_req = 1'b0;
  logic       vblank = 1'b0;
  logic       pause;
  logic       hs_grant;
  logic       user_paused;
  logic       dim_video;
  logic [1:0] dbg_state;

  int total = 0;
  int bad = 0;

`ifdef PAUSE_ARB_DIM_EN
  localparam bit DIM_ON = 1'b1;
`else
  localparam bit DIM_ON = 1'b0;
`endif

  pause_arbiter #(
    .SETTLE_CYCLES(4),
    .VBL_TIMEOUT(100),
    .DIM_CYCLES(10),
    .TW(32)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_btn_pause(btn_pause),
    .i_osd_open(osd_open),
    .i_osd_pause_en(osd_pause_en),
    .i_hs_req(hs_req),
    .i_vblank(vblank),
    .o_pause(pause),
    .o_hs_grant(hs_grant),
    .o_user_paused(user_paused),
    .o_dim_video(dim_video),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn_pause = 1'b0;
    osd_open = 1'b0;
    osd_pause_en = 1'b0;
    hs_req = 1'b0;
    vblank = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    hs_req = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({pause, hs_grant, user_paused, dim_video} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0000", {pause, hs_grant, user_paused, dim_video});
    end
    total++;
    if (dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_state got=%0d exp=0", dbg_state);
    end
    do_reset();
  endtask

  task automatic test_vblank_grant();
    do_reset();
    for (int c = 0; c <= 42; c++) begin
      total++;
      if (pause !== (c >= 21 && c <= 40)) begin
        bad++;
        $display("FAIL vbl_pause c=%0d got=%b exp=%b", c, pause, (c >= 21 && c <= 40));
      end
      total++;
      if (hs_grant !== (c >= 25 && c <= 40)) begin
        bad++;
        $display("FAIL vbl_grant c=%0d got=%b exp=%b", c, hs_grant, (c >= 25 && c <= 40));
      end
      total++;
      if (dim_video !== 1'b0) begin
        bad++;
        $display("FAIL vbl_dim c=%0d got=%b exp=0", c, dim_video);
      end
      hs_req = (c < 40);
      vblank = (c >= 20 && c < 30);
      tick();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 0; c <= 108; c++) begin
      total++;
      if (pause !== (c >= 101 && c <= 107)) begin
        bad++;
        $display("FAIL tmo_pause c=%0d got=%b exp=%b", c, pause, (c >= 101 && c <= 107));
      end
      total++;
      if (hs_grant !== (c >= 105 && c <= 107)) begin
        bad++;
        $display("FAIL tmo_grant c=%0d got=%b exp=%b", c, hs_grant, (c >= 105 && c <= 107));
      end
      hs_req = (c < 107);
      tick();
    end
  endtask

  task automatic test_user_hold();
    do_reset();
    for (int c = 0; c <= 19; c++) begin
      total++;
      if (pause !== (c >= 6 && c <= 17)) begin
        bad++;
        $display("FAIL user_pause c=%0d got=%b exp=%b", c, pause, (c >= 6 && c <= 17));
      end
      total++;
      if (hs_grant !== 1'b0) begin
        bad++;
        $display("FAIL user_grant c=%0d got=%b exp=0", c, hs_grant);
      end
      total++;
      if (user_paused !== (c >= 7 && c <= 16)) begin
        bad++;
        $display("FAIL user_flag c=%0d got=%b exp=%b", c, user_paused, (c >= 7 && c <= 16));
      end
      if (c == 10 || c == 15) begin
        total++;
        if (dbg_state !== 2'd3) begin
          bad++;
          $display("FAIL user_hold_state c=%0d got=%0d exp=3", c, dbg_state);
        end
      end
      hs_req = (c < 8);
      vblank = (c >= 5);
      btn_pause = (c == 6 || c == 16);
      tick();
    end
  endtask

  task automatic test_osd();
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      total++;
      if (pause !== (c >= 16 && c <= 19)) begin
        bad++;
        $display("FAIL osd_pause c=%0d got=%b exp=%b", c, pause, (c >= 16 && c <= 19));
      end
      total++;
      if (hs_grant !== 1'b0) begin
        bad++;
        $display("FAIL osd_grant c=%0d got=%b exp=0", c, hs_grant);
      end
      if (c >= 1 && c <= 10) begin
        total++;
        if (dbg_state !== 2'd0) begin
          bad++;
          $display("FAIL osd_disabled_state c=%0d got=%0d exp=0", c, dbg_state);
        end
      end
      osd_open = (c < 19);
      osd_pause_en = (c >= 10);
      vblank = (c == 15);
      tick();
    end
  endtask

  task automatic test_reset_cases();
    btn_pause = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    total++;
    if (user_paused !== 1'b0) begin
      bad++;
      $display("FAIL held_btn_toggle got=%b exp=0", user_paused);
    end
    btn_pause = 1'b0;
    tick();
    total++;
    if (user_paused !== 1'b0) begin
      bad++;
      $display("FAIL held_btn_release got=%b exp=0", user_paused);
    end
    for (int c = 0; c <= 10; c++) begin
      total++;
      if (pause !== (c >= 3 && c <= 9)) begin
        bad++;
        $display("FAIL rst_hold_pause c=%0d got=%b exp=%b", c, pause, (c >= 3 && c <= 9));
      end
      total++;
      if (hs_grant !== (c >= 7 && c <= 9)) begin
        bad++;
        $display("FAIL rst_hold_grant c=%0d got=%b exp=%b", c, hs_grant, (c >= 7 && c <= 9));
      end
      hs_req = 1'b1;
      vblank = (c == 2);
      reset = (c == 9);
      tick();
    end
    reset = 1'b0;
    hs_req = 1'b0;
    tick();
  endtask

  task automatic test_dim();
    do_reset();
    for (int c = 0; c <= 24; c++) begin
      total++;
      if (dim_video !== (DIM_ON && c >= 18 && c <= 21)) begin
        bad++;
        $display("FAIL dim_video c=%0d got=%b exp=%b", c, dim_video, (DIM_ON && c >= 18 && c <= 21));
      end
      total++;
      if (pause !== (c >= 4 && c <= 21)) begin
        bad++;
        $display("FAIL dim_pause c=%0d got=%b exp=%b", c, pause, (c >= 4 && c <= 21));
      end
      btn_pause = (c == 0 || c == 20);
      vblank = (c == 3);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_vblank_grant();
    test_timeout();
    test_user_hold();
    test_osd();
    test_reset_cases();
    test_dim();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
